cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning number of upstream cbus requesters (legal range 2..8).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_PORTS), meaning width of the grant index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ireqs  input  NUM_PORTS x cbus_req_t  upstream requests.
REQ-006 SHALL have port iresps  output  NUM_PORTS x cbus_resp_t  upstream responses.
REQ-007 SHALL have port oreq  output  cbus_req_t  downstream request to the memory helper.
REQ-008 SHALL have port oresp  input  cbus_resp_t  downstream response (ready, last, data).
REQ-009 SHALL have port grant  output  NUM_PORTS  one-hot owner of the bus; all zero when idle.
REQ-010 SHALL have port busy  output  1  high while a transaction is owned.

Function
REQ-011 SHALL implement two states: IDLE and BUSY.
REQ-012 In IDLE, if any ireqs[i].valid is high, the arbiter SHALL register the winner index at the next edge and enter BUSY.
- Latency: request first sampled in cycle t; oreq.valid high in cycle t+1.
REQ-013 In IDLE, with no valid request, the arbiter SHALL remain in IDLE.
REQ-014 In BUSY, oreq SHALL equal ireqs[sel] combinationally.
REQ-015 In BUSY, iresps[sel] SHALL equal oresp.
REQ-016 All non-selected iresps entries SHALL be all-zero, and in IDLE every iresps entry SHALL be all-zero.
REQ-017 In IDLE, oreq SHALL be all-zero.
REQ-018 BUSY SHALL exit to IDLE on the edge where oresp.ready and oresp.last are both high.
- The next arbitration SHALL occur in the following IDLE cycle, giving a minimum of one idle cycle between transactions.
REQ-019 If ireqs[sel].valid drops while the arbiter is BUSY, the arbiter SHALL stay BUSY, forward valid=0, and still wait for last; the requester is responsible for holding the request.
REQ-020 Grant SHALL never change mid-transaction, regardless of other requests.
REQ-021 When several requests are valid simultaneously, the winner SHALL be chosen per REQ-026/027.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE, sel=0, round-robin pointer=0, grant=0, busy=0, and oreq all-zero.
REQ-023 Reset asserted mid-burst SHALL abandon the transaction; no response SHALL be forwarded after reset.
REQ-024 After reset deasserts, the first arbitration SHALL occur no earlier than the first rising edge.

Configuration
REQ-025 Macro CBUS_ARB_RR_EN SHALL select the arbitration policy.
REQ-026 With CBUS_ARB_RR_EN defined: round-robin.
- A pointer, reset to 0, marks the highest-priority port.
- The winner is the first valid port at or after the pointer, wrapping modulo NUM_PORTS.
- On BUSY exit, the pointer becomes (sel+1) mod NUM_PORTS.
REQ-027 Without CBUS_ARB_RR_EN: fixed priority, with the lowest index winning; the pointer register SHALL not exist.

Structure
REQ-028 cbus_req_t, cbus_resp_t, and any arbiter state enum SHALL reside in the common package.
REQ-029 Winner selection SHALL be a sub-module, rr_picker (inputs: valid vector and pointer; output: one-hot winner), reused by both policies with pointer tied to 0 in fixed mode.
REQ-030 SimTop's USE_VTOP path SHALL instantiate cbus_arbiter with NUM_PORTS=2 (port 0 = instruction, port 1 = data).

Verification
REQ-031 Single request: port 1 valid at cycle 5, 4-beat burst, last at beat 4 -> oreq.valid at cycle 6, grant=2'b10, busy falls after the last edge, iresps[0] all-zero throughout.
REQ-032 Round-robin (RR_EN, N=4): all ports continuously valid, single-beat responses -> grant sequence 0,1,2,3,0, with one idle cycle between each.
REQ-033 Fixed priority (no RR_EN, N=4): ports 1 and 3 continuously valid -> port 1 always wins; port 3 is never granted while port 1 is valid.
REQ-034 Mid-burst contention: port 0 owns an 8-beat burst while port 1 asserts valid at beat 2 -> grant stays 0 until last, then port 1 is granted.
REQ-035 Reset at beat 3 of a burst -> same-cycle grant=0, busy=0, oreq all-zero; after release, a pending port 0 request is granted one cycle later and the pointer restarts at 0.
REQ-036 Valid dropped mid-burst -> busy held, oreq.valid=0, exit only on oresp.last with oresp.ready.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: shared cbus request/response types and arbiter state encodings.
package cbus_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_BUSY = 1'b1;
endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// rr_picker: one-hot pick of the first valid bit at or after ptr, wrapping to bit 0.
module rr_picker #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] winner
);
  logic [N-1:0] masked, pick;
  assign masked = valid & ~((N'(1) << ptr) - N'(1));
  assign pick = |masked ? masked : valid;
  // lowest set bit of pick
  assign winner = pick & (~pick + N'(1));
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one whole cbus burst at a time to one of NUM_PORTS requesters.
// Define CBUS_ARB_RR_EN for round-robin; otherwise fixed priority with the lowest index winning.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_PORTS-1:0]   ireqs,
  output cbus_resp_t [NUM_PORTS-1:0]   iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic       [NUM_PORTS-1:0]   grant,
  output logic                         busy
);
  arb_state_t state;
  logic [IDX_W-1:0] sel, ptr, win_idx;
  logic [NUM_PORTS-1:0] valids, winner;
  logic done;
  assign busy = state == ST_BUSY;
  assign done = busy && oresp.ready && oresp.last;
  always_comb begin
    valids = '0;
    for (int i = 0; i < NUM_PORTS; i++) valids[i] = ireqs[i].valid;
  end
  rr_picker #(.N(NUM_PORTS), .W(IDX_W)) u_picker (
    .valid(valids),
    .ptr(ptr),
    .winner(winner)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (winner[i]) win_idx = IDX_W'(i);
  end
`ifdef CBUS_ARB_RR_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (done) ptr <= (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
`else
  assign ptr = '0;
`endif
  // arbitration only happens from IDLE, so the owner is frozen for the whole burst
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      sel <= '0;
    end else if (!busy && |valids) begin
      state <= ST_BUSY;
      sel <= win_idx;
    end else if (done) state <= ST_IDLE;
  assign grant = busy ? NUM_PORTS'(1) << sel : '0;
  assign oreq = busy ? ireqs[sel] : '0;
  always_comb begin
    iresps = '0;
    if (busy) iresps[sel] = oresp;
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed self-checking bench for cbus_arbiter with four ports.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset;
  cbus_req_t  [N-1:0] ireqs;
  cbus_resp_t [N-1:0] iresps;
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [N-1:0] grant;
  logic busy;
  int checks = 0;
  int failures = 0;

  cbus_arbiter #(.NUM_PORTS(N)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
    .oreq(oreq), .oresp(oresp), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk_req(int p, logic v);
    mk_req = '0;
    mk_req.valid = v;
    mk_req.write = p[0];
    mk_req.addr = 32'h1000_0000 + 32'(p) * 32'h100;
    mk_req.wdata = {32'hA5A5_0000 + 32'(p), 32'h5A5A_0000 + 32'(p)};
    mk_req.wmask = 8'hF0 | 8'(p);
  endfunction

  task automatic set_valid(logic [N-1:0] v);
    for (int i = 0; i < N; i++) ireqs[i] = mk_req(i, v[i]);
  endtask

  task automatic set_resp(logic rdy, logic lst, logic [63:0] d);
    oresp.ready = rdy;
    oresp.last = lst;
    oresp.data = d;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    set_valid('0);
    set_resp(1'b0, 1'b0, 64'h0);
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_valid(4'b1111);
    set_resp(1'b1, 1'b1, 64'hDEAD);
    tick;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl grant=%b busy=%b expected grant=0000 busy=0", grant, busy);
    end
    checks++;
    if (oreq !== '0 || iresps !== '0) begin
      failures++;
      $display("FAIL reset_outputs oreq=%h iresps=%h expected all zero", oreq, iresps);
    end
    set_valid(4'b0001);
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_no_edge busy=%b expected 0", busy);
    end
    tick;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant busy=%b grant=%b expected busy=1 grant=0001", busy, grant);
    end
  endtask

  task automatic test_single;
    cbus_resp_t er;
    do_reset;
    set_valid(4'b0010);
    #1;
    checks++;
    if (busy !== 1'b0 || oreq !== '0) begin
      failures++;
      $display("FAIL single_idle busy=%b oreq=%h expected busy=0 oreq=0", busy, oreq);
    end
    tick;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL single_grant busy=%b grant=%b expected busy=1 grant=0010", busy, grant);
    end
    checks++;
    if (oreq !== mk_req(1, 1'b1)) begin
      failures++;
      $display("FAIL single_oreq got=%h expected=%h", oreq, mk_req(1, 1'b1));
    end
    for (int b = 1; b <= 4; b++) begin
      set_resp(1'b1, b == 4, 64'h100 + 64'(b));
      er.ready = 1'b1;
      er.last = (b == 4);
      er.data = 64'h100 + 64'(b);
      #1;
      checks++;
      if (iresps[1] !== er || grant !== 4'b0010) begin
        failures++;
        $display("FAIL single_beat%0d iresps1=%h grant=%b expected %h/0010", b, iresps[1], grant, er);
      end
      checks++;
      if (iresps[0] !== '0 || iresps[2] !== '0 || iresps[3] !== '0) begin
        failures++;
        $display("FAIL single_other_resp beat%0d iresps=%h expected only port1 nonzero", b, iresps);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || iresps !== '0 || oreq !== '0) begin
      failures++;
      $display("FAIL single_exit busy=%b grant=%b iresps=%h oreq=%h expected idle all zero", busy, grant, iresps, oreq);
    end
    set_valid('0);
    set_resp(1'b0, 1'b0, 64'h0);
    tick;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_stay_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_priority;
    int exp_a[5];
    int exp_b[3];
    logic [N-1:0] eg;
`ifdef CBUS_ARB_RR_EN
    exp_a = '{0, 1, 2, 3, 0};
    exp_b = '{1, 3, 1};
`else
    exp_a = '{0, 0, 0, 0, 0};
    exp_b = '{1, 1, 1};
`endif
    do_reset;
    set_resp(1'b1, 1'b1, 64'h77);
    set_valid(4'b1111);
    for (int k = 0; k < 5; k++) begin
      tick;
      eg = 4'b0001 << exp_a[k];
      checks++;
      if (busy !== 1'b1 || grant !== eg || oreq !== mk_req(exp_a[k], 1'b1)) begin
        failures++;
        $display("FAIL prio_all_%0d busy=%b grant=%b expected busy=1 grant=%b", k, busy, grant, eg);
      end
      tick;
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
        failures++;
        $display("FAIL prio_all_gap_%0d busy=%b grant=%b expected idle", k, busy, grant);
      end
    end
    set_valid(4'b1010);
    for (int k = 0; k < 3; k++) begin
      tick;
      eg = 4'b0001 << exp_b[k];
      checks++;
      if (busy !== 1'b1 || grant !== eg || oreq !== mk_req(exp_b[k], 1'b1)) begin
        failures++;
        $display("FAIL prio_13_%0d busy=%b grant=%b expected busy=1 grant=%b", k, busy, grant, eg);
      end
      tick;
    end
  endtask

  task automatic test_contention;
    do_reset;
    set_valid(4'b0001);
    set_resp(1'b1, 1'b0, 64'h0);
    tick;
    for (int b = 1; b <= 8; b++) begin
      if (b == 2) set_valid(4'b0011);
      set_resp(1'b1, b == 8, 64'(b));
      #1;
      checks++;
      if (busy !== 1'b1 || grant !== 4'b0001 || iresps[1] !== '0) begin
        failures++;
        $display("FAIL contend_beat%0d busy=%b grant=%b iresps1=%h expected busy=1 grant=0001 iresps1=0", b, busy, grant, iresps[1]);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL contend_gap busy=%b expected 0", busy);
    end
    set_valid(4'b0010);
    tick;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL contend_next busy=%b grant=%b expected busy=1 grant=0010", busy, grant);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_valid(4'b0010);
    set_resp(1'b1, 1'b1, 64'h0);
    tick;
    tick;
    set_valid(4'b1000);
    set_resp(1'b1, 1'b0, 64'h33);
    tick;
    tick;
    tick;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_pre busy=%b grant=%b expected busy=1 grant=1000", busy, grant);
    end
    set_valid(4'b1011);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || oreq !== '0 || iresps !== '0) begin
      failures++;
      $display("FAIL rstmid_async busy=%b grant=%b oreq=%h iresps=%h expected all zero", busy, grant, oreq, iresps);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || iresps !== '0) begin
      failures++;
      $display("FAIL rstmid_release busy=%b iresps=%h expected idle", busy, iresps);
    end
    tick;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_regrant busy=%b grant=%b expected busy=1 grant=0001", busy, grant);
    end
  endtask

  task automatic test_valid_drop;
    cbus_resp_t er;
    do_reset;
    set_valid(4'b0100);
    set_resp(1'b0, 1'b0, 64'h0);
    tick;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0100) begin
      failures++;
      $display("FAIL drop_grant busy=%b grant=%b expected busy=1 grant=0100", busy, grant);
    end
    set_valid('0);
    #1;
    checks++;
    if (busy !== 1'b1 || oreq.valid !== 1'b0 || oreq !== mk_req(2, 1'b0)) begin
      failures++;
      $display("FAIL drop_forward busy=%b oreq=%h expected busy=1 oreq=%h", busy, oreq, mk_req(2, 1'b0));
    end
    set_resp(1'b1, 1'b0, 64'h1);
    tick;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_ready_only busy=%b expected 1", busy);
    end
    set_resp(1'b0, 1'b1, 64'h2);
    er.ready = 1'b0;
    er.last = 1'b1;
    er.data = 64'h2;
    tick;
    checks++;
    if (busy !== 1'b1 || iresps[2] !== er) begin
      failures++;
      $display("FAIL drop_last_only busy=%b iresps2=%h expected busy=1 iresps2=%h", busy, iresps[2], er);
    end
    set_resp(1'b1, 1'b1, 64'h3);
    tick;
    checks++;
    if (busy !== 1'b0 || oreq !== '0) begin
      failures++;
      $display("FAIL drop_exit busy=%b oreq=%h expected busy=0 oreq=0", busy, oreq);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_contention;
    test_reset_mid;
    test_valid_drop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
